// File: rtl/rv32i_hazard_pkg.sv
// Shared opcode constants, the load result-select code and the scoreboard entry layout
// used by the RV32I load-use hazard scoreboard.
package rv32i_hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Countdown field is wide enough for any LOAD_LAT up to 256.
    localparam int SB_CNT_W = 8;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

    // x0 never creates a dependency; an unused source field never matches.
    function automatic logic rs_match(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic use_rs);
        return use_rs && (rs != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/load_sb_entry.sv
// One scoreboard entry: holds the destination of an in-flight load and counts down
// until its data is forwardable. Reports liveness and a source-register match.
module load_sb_entry
    import rv32i_hazard_pkg::*;
#(
    parameter int CNT_INIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_alloc,
    input  logic       i_dec,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs1,
    input  logic       i_use_rs2,
    output logic       o_live,
    output logic       o_busy_next,
    output logic       o_match
);

    sb_entry_t r_entry;
    logic      w_live;

    assign w_live = r_entry.valid && (r_entry.cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry <= '0;
        end else if (i_alloc) begin
            r_entry.valid <= 1'b1;
            r_entry.rd    <= i_rd;
            r_entry.cnt   <= SB_CNT_W'(CNT_INIT);
        end else if (i_dec && w_live) begin
            // Reaching zero frees the slot on this very edge.
            r_entry.cnt <= r_entry.cnt - 1'b1;
            if (r_entry.cnt == SB_CNT_W'(1))
                r_entry.valid <= 1'b0;
        end
    end

    assign o_live      = w_live;
    assign o_busy_next = w_live && (r_entry.cnt > SB_CNT_W'(1));
    assign o_match     = w_live && (rs_match(r_entry.rd, i_rs1, i_use_rs1) ||
                                    rs_match(r_entry.rd, i_rs2, i_use_rs2));

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard detector with an in-flight load scoreboard (LOAD_LAT cycles of load latency).
// Optional stall-cycle counter is built when LOAD_HAZARD_PERF_EN is defined.
module load_hazard_scoreboard
    import rv32i_hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MAX_OUT  = 2,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ResultSrcE,
    input  logic [4:0]        RD_E,
    input  logic              flushE_in,
    input  logic              freeze,
    input  logic [31:0]       InstrD,
    input  logic              validD,
    output logic              pc_write,
    output logic              stallF_load_hazard,
    output logic              stallD_load_hazard,
    output logic              flushE_load_hazard,
    output logic              sb_busy,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_ex_load;
    logic       w_ex_hz;
    logic       w_sb_hz;
    logic       w_full_hz;
    logic       w_any_live;
    logic       w_stall;
    logic       w_unused;

    assign w_opcode  = InstrD[6:0];
    assign w_rs1     = InstrD[19:15];
    assign w_rs2     = InstrD[24:20];
    assign w_use_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
    assign w_use_rs2 = (w_opcode == OP_RTYPE) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
    assign w_unused  = ^{InstrD[31:25], InstrD[14:7], freeze};

    assign w_ex_load = (ResultSrcE == RESULT_SRC_LOAD) && (RD_E != 5'd0) && !flushE_in;
    assign w_ex_hz   = w_ex_load && (rs_match(RD_E, w_rs1, w_use_rs1) ||
                                     rs_match(RD_E, w_rs2, w_use_rs2));

    generate
        if (LOAD_LAT > 1) begin : g_sb
            logic [MAX_OUT-1:0] w_live;
            logic [MAX_OUT-1:0] w_busy_next;
            logic [MAX_OUT-1:0] w_match;
            logic [MAX_OUT-1:0] w_alloc;
            logic               w_found;
            int                 w_occ;

            always_comb begin
                w_alloc = '0;
                w_found = 1'b0;
                for (int i = 0; i < MAX_OUT; i++) begin
                    if (!w_live[i] && !w_found) begin
                        w_alloc[i] = w_ex_load && !freeze;
                        w_found    = 1'b1;
                    end
                end
            end

            // Occupancy as seen when a load now in D reaches EX: entries expiring on
            // this edge are already free by then, so only cnt>1 entries still hold a slot.
            always_comb begin
                w_occ = 0;
                for (int i = 0; i < MAX_OUT; i++)
                    if (w_busy_next[i]) w_occ = w_occ + 1;
                if (w_ex_load) w_occ = w_occ + 1;
            end

            for (genvar i = 0; i < MAX_OUT; i++) begin : g_entry
                load_sb_entry #(
                    .CNT_INIT(LOAD_LAT - 1)
                ) u_entry (
                    .clk        (clk),
                    .rst        (rst),
                    .i_alloc    (w_alloc[i]),
                    .i_dec      (!freeze),
                    .i_rd       (RD_E),
                    .i_rs1      (w_rs1),
                    .i_rs2      (w_rs2),
                    .i_use_rs1  (w_use_rs1),
                    .i_use_rs2  (w_use_rs2),
                    .o_live     (w_live[i]),
                    .o_busy_next(w_busy_next[i]),
                    .o_match    (w_match[i])
                );
            end

            always_ff @(posedge clk) begin
                if (!rst && w_ex_load && !freeze)
                    assert (!(&w_live));
            end

            assign w_sb_hz    = |w_match;
            assign w_any_live = |w_live;
            assign w_full_hz  = (w_opcode == OP_LOAD) && (w_occ >= MAX_OUT);
        end else begin : g_no_sb
            assign w_sb_hz    = 1'b0;
            assign w_any_live = 1'b0;
            assign w_full_hz  = 1'b0;
        end
    endgenerate

    assign w_stall = !rst && validD && (w_ex_hz || w_sb_hz || w_full_hz);

    assign pc_write           = !w_stall;
    assign stallF_load_hazard = w_stall;
    assign stallD_load_hazard = w_stall;
    assign flushE_load_hazard = w_stall;
    assign sb_busy            = !rst && w_any_live;

`ifdef LOAD_HAZARD_PERF_EN
    logic [PERF_W-1:0] r_perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_perf_cnt <= '0;
        else if (w_stall && !freeze && (r_perf_cnt != '1))
            r_perf_cnt <= r_perf_cnt + 1'b1;
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
